// File: rtl/ascon_mc_dispatch.sv
// Round-robin front end sharing one 32-bit ASCON core among NUM_CH requesters.
// Sessions are owner-locked from grant to core done, with an idle watchdog.
module ascon_mc_dispatch #(
    parameter  int NUM_CH        = 4,
    parameter  int TIMEOUT_CYC   = 1024,
    parameter  int ABORT_RST_CYC = 2,
    localparam int CH_W          = $clog2(NUM_CH)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_CH-1:0]    ch_key_valid_i,
    input  logic [NUM_CH-1:0]    ch_key_last_i,
    input  logic [NUM_CH-1:0]    ch_bd_valid_i,
    input  logic [NUM_CH-1:0]    ch_bd_last_i,
    input  logic [NUM_CH-1:0]    ch_eoi_i,
    input  logic [NUM_CH-1:0]    ch_bdo_ready_i,
    input  logic [32*NUM_CH-1:0] ch_key_i,
    input  logic [32*NUM_CH-1:0] ch_bd_i,
    input  logic [3*NUM_CH-1:0]  ch_bd_type_i,
    input  logic [4*NUM_CH-1:0]  ch_bd_vld_byte_i,
    output logic [NUM_CH-1:0]    ch_key_ready_o,
    output logic [NUM_CH-1:0]    ch_bdi_ready_o,
    output logic [NUM_CH-1:0]    ch_bd_valid_o,
    output logic [NUM_CH-1:0]    ch_bd_last_o,
    output logic [32*NUM_CH-1:0] ch_bd_o,
    output logic [3*NUM_CH-1:0]  ch_bd_type_o,
    output logic [4*NUM_CH-1:0]  ch_bd_vld_byte_o,
    output logic [NUM_CH-1:0]    ch_done_o,
    output logic [NUM_CH-1:0]    ch_auth_valid_o,
    output logic [NUM_CH-1:0]    ch_tag_match_o,
    output logic [NUM_CH-1:0]    ch_timeout_o,
    output logic                 core_key_valid_o,
    output logic                 core_key_last_o,
    output logic                 core_bd_valid_o,
    output logic                 core_bd_last_o,
    output logic                 core_eoi_o,
    output logic                 core_bdo_ready_o,
    output logic [31:0]          core_key_o,
    output logic [31:0]          core_bd_o,
    output logic [2:0]           core_bd_type_o,
    output logic [3:0]           core_bd_vld_byte_o,
    input  logic                 core_key_ready_i,
    input  logic                 core_bdi_ready_i,
    input  logic                 core_bd_valid_i,
    input  logic                 core_bd_last_i,
    input  logic                 core_auth_valid_i,
    input  logic                 core_tag_match_i,
    input  logic                 core_ready_i,
    input  logic                 core_done_i,
    input  logic [31:0]          core_bd_i,
    input  logic [2:0]           core_bd_type_i,
    input  logic [3:0]           core_bd_vld_byte_i,
    output logic                 core_rst_n_o,
    output logic                 busy_o,
    output logic [CH_W-1:0]      owner_o
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int AB_W = (ABORT_RST_CYC > 1) ? $clog2(ABORT_RST_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [AB_W-1:0] AB_LAST =
        AB_W'((ABORT_RST_CYC == 0) ? 0 : ABORT_RST_CYC - 1);

    typedef enum logic [1:0] {IDLE, GRANT, SESS, ABORT} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   owner_q, owner_d, rr_q, rr_d, owner_nxt, pick;
    logic [NUM_CH-1:0] req, done_q, auth_q, tag_q, tmo_q;
    logic [WD_W-1:0]   wd_q;
    logic [AB_W-1:0]   ab_q;
    logic              sel, hs, wd_exp;
    int                idx;

    assign req       = ch_key_valid_i | ch_bd_valid_i;
    assign sel       = (state_q == SESS);
    assign owner_nxt = (owner_q == CH_W'(NUM_CH - 1)) ? '0 : owner_q + 1'b1;

    // Walk downward so the lowest offset from rr_q is the one left standing.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % NUM_CH;
            if (req[idx]) pick = CH_W'(idx);
        end
    end

    always_comb begin
        core_key_valid_o   = 1'b0;
        core_key_last_o    = 1'b0;
        core_bd_valid_o    = 1'b0;
        core_bd_last_o     = 1'b0;
        core_eoi_o         = 1'b0;
        core_bdo_ready_o   = 1'b0;
        core_key_o         = '0;
        core_bd_o          = '0;
        core_bd_type_o     = '0;
        core_bd_vld_byte_o = '0;
        ch_key_ready_o     = '0;
        ch_bdi_ready_o     = '0;
        ch_bd_valid_o      = '0;
        ch_bd_last_o       = '0;
        ch_bd_o            = '0;
        ch_bd_type_o       = '0;
        ch_bd_vld_byte_o   = '0;
        if (sel) begin
            core_key_valid_o   = ch_key_valid_i[owner_q];
            core_key_last_o    = ch_key_last_i[owner_q];
            core_bd_valid_o    = ch_bd_valid_i[owner_q];
            core_bd_last_o     = ch_bd_last_i[owner_q];
            core_eoi_o         = ch_eoi_i[owner_q];
            core_bdo_ready_o   = ch_bdo_ready_i[owner_q];
            core_key_o         = ch_key_i[32*owner_q +: 32];
            core_bd_o          = ch_bd_i[32*owner_q +: 32];
            core_bd_type_o     = ch_bd_type_i[3*owner_q +: 3];
            core_bd_vld_byte_o = ch_bd_vld_byte_i[4*owner_q +: 4];
            ch_key_ready_o[owner_q]             = core_key_ready_i;
            ch_bdi_ready_o[owner_q]             = core_bdi_ready_i;
            ch_bd_valid_o[owner_q]              = core_bd_valid_i;
            ch_bd_last_o[owner_q]               = core_bd_last_i;
            ch_bd_o[32*owner_q +: 32]           = core_bd_i;
            ch_bd_type_o[3*owner_q +: 3]        = core_bd_type_i;
            ch_bd_vld_byte_o[4*owner_q +: 4]    = core_bd_vld_byte_i;
        end
    end

    assign hs = (core_key_valid_o & core_key_ready_i)
              | (core_bd_valid_o & core_bdi_ready_i)
              | (sel & core_bd_valid_i & core_bdo_ready_o);

    assign wd_exp = (TIMEOUT_CYC != 0) && !hs && (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if ((|req) && core_ready_i) begin
                    owner_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: state_d = SESS;
            SESS: begin
                if (core_done_i) begin
                    rr_d    = owner_nxt;
                    state_d = IDLE;
                end else if (wd_exp) begin
                    rr_d    = owner_nxt;
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (ab_q == AB_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            wd_q    <= '0;
            ab_q    <= '0;
            done_q  <= '0;
            auth_q  <= '0;
            tag_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            done_q  <= '0;
            if (state_q == IDLE && state_d == GRANT) begin
                auth_q[owner_d] <= 1'b0;
                tag_q[owner_d]  <= 1'b0;
                tmo_q[owner_d]  <= 1'b0;
            end
            if (state_q == GRANT) begin
                wd_q <= '0;
            end else if (sel) begin
                wd_q <= (hs || core_done_i) ? '0 : wd_q + 1'b1;
            end
            if (sel && core_done_i) begin
                auth_q[owner_q] <= core_auth_valid_i;
                tag_q[owner_q]  <= core_tag_match_i;
                done_q[owner_q] <= 1'b1;
            end else if (sel && wd_exp) begin
                tmo_q[owner_q]  <= 1'b1;
                done_q[owner_q] <= 1'b1;
                ab_q            <= '0;
            end
            if (state_q == ABORT) ab_q <= ab_q + 1'b1;
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign core_rst_n_o    = (state_q != ABORT);
    assign owner_o         = owner_q;
    assign ch_done_o       = done_q;
    assign ch_auth_valid_o = auth_q;
    assign ch_tag_match_o  = tag_q;
    assign ch_timeout_o    = tmo_q;

endmodule

// File: tb/tb_ascon_mc_dispatch.sv
// Bench for ascon_mc_dispatch: arbitration table, random sessions and
// hand-built back-pressure, watchdog, collision and async-reset sequences.
module tb_ascon_mc_dispatch;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   ch_key_valid_i, ch_key_last_i, ch_bd_valid_i;
    logic [N-1:0]   ch_bd_last_i, ch_eoi_i, ch_bdo_ready_i;
    logic [32*N-1:0] ch_key_i, ch_bd_i;
    logic [3*N-1:0] ch_bd_type_i;
    logic [4*N-1:0] ch_bd_vld_byte_i;
    logic [N-1:0]   ch_key_ready_o, ch_bdi_ready_o, ch_bd_valid_o, ch_bd_last_o;
    logic [32*N-1:0] ch_bd_o;
    logic [3*N-1:0] ch_bd_type_o;
    logic [4*N-1:0] ch_bd_vld_byte_o;
    logic [N-1:0]   ch_done_o, ch_auth_valid_o, ch_tag_match_o, ch_timeout_o;
    logic           core_key_valid_o, core_key_last_o, core_bd_valid_o;
    logic           core_bd_last_o, core_eoi_o, core_bdo_ready_o;
    logic [31:0]    core_key_o, core_bd_o;
    logic [2:0]     core_bd_type_o;
    logic [3:0]     core_bd_vld_byte_o;
    logic           core_key_ready_i, core_bdi_ready_i, core_bd_valid_i;
    logic           core_bd_last_i, core_auth_valid_i, core_tag_match_i;
    logic           core_ready_i, core_done_i;
    logic [31:0]    core_bd_i;
    logic [2:0]     core_bd_type_i;
    logic [3:0]     core_bd_vld_byte_i;
    logic           core_rst_n_o, busy_o;
    logic [1:0]     owner_o;

    ascon_mc_dispatch #(
        .NUM_CH(N), .TIMEOUT_CYC(16), .ABORT_RST_CYC(2)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ch_key_valid_i(ch_key_valid_i), .ch_key_last_i(ch_key_last_i),
        .ch_bd_valid_i(ch_bd_valid_i), .ch_bd_last_i(ch_bd_last_i),
        .ch_eoi_i(ch_eoi_i), .ch_bdo_ready_i(ch_bdo_ready_i),
        .ch_key_i(ch_key_i), .ch_bd_i(ch_bd_i),
        .ch_bd_type_i(ch_bd_type_i), .ch_bd_vld_byte_i(ch_bd_vld_byte_i),
        .ch_key_ready_o(ch_key_ready_o), .ch_bdi_ready_o(ch_bdi_ready_o),
        .ch_bd_valid_o(ch_bd_valid_o), .ch_bd_last_o(ch_bd_last_o),
        .ch_bd_o(ch_bd_o), .ch_bd_type_o(ch_bd_type_o),
        .ch_bd_vld_byte_o(ch_bd_vld_byte_o),
        .ch_done_o(ch_done_o), .ch_auth_valid_o(ch_auth_valid_o),
        .ch_tag_match_o(ch_tag_match_o), .ch_timeout_o(ch_timeout_o),
        .core_key_valid_o(core_key_valid_o), .core_key_last_o(core_key_last_o),
        .core_bd_valid_o(core_bd_valid_o), .core_bd_last_o(core_bd_last_o),
        .core_eoi_o(core_eoi_o), .core_bdo_ready_o(core_bdo_ready_o),
        .core_key_o(core_key_o), .core_bd_o(core_bd_o),
        .core_bd_type_o(core_bd_type_o),
        .core_bd_vld_byte_o(core_bd_vld_byte_o),
        .core_key_ready_i(core_key_ready_i), .core_bdi_ready_i(core_bdi_ready_i),
        .core_bd_valid_i(core_bd_valid_i), .core_bd_last_i(core_bd_last_i),
        .core_auth_valid_i(core_auth_valid_i),
        .core_tag_match_i(core_tag_match_i),
        .core_ready_i(core_ready_i), .core_done_i(core_done_i),
        .core_bd_i(core_bd_i), .core_bd_type_i(core_bd_type_i),
        .core_bd_vld_byte_i(core_bd_vld_byte_i),
        .core_rst_n_o(core_rst_n_o), .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         own;
        logic       auth;
        logic       tag;
    } vec_t;

    vec_t tbl[10];
    int   checks   = 0;
    int   failures = 0;
    int   m_rr     = 0;

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] req, input int rr);
        for (int i = 0; i < N; i++)
            if (req[(rr + i) % N]) return (rr + i) % N;
        return 0;
    endfunction

    function automatic logic [3:0] oh(input int c);
        return 4'(1 << c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ch_key_valid_i = '0; ch_key_last_i = '0; ch_bd_valid_i = '0;
        ch_bd_last_i = '0; ch_eoi_i = '0; ch_bdo_ready_i = '0;
        ch_key_i = '0; ch_bd_i = '0; ch_bd_type_i = '0; ch_bd_vld_byte_i = '0;
        core_key_ready_i = 1'b1; core_bdi_ready_i = 1'b1;
        core_bd_valid_i = 1'b0; core_bd_last_i = 1'b0;
        core_auth_valid_i = 1'b0; core_tag_match_i = 1'b0;
        core_ready_i = 1'b1; core_done_i = 1'b0;
        core_bd_i = '0; core_bd_type_i = '0; core_bd_vld_byte_i = '0;
    endtask

    task automatic run_session(input logic [3:0] req, input int own,
                               input logic auth, input logic tag,
                               input int hold);
        logic [127:0] e;
        for (int c = 0; c < N; c++) begin
            ch_key_i[32*c +: 32] = $urandom;
            ch_bd_i[32*c +: 32]  = $urandom;
            ch_bd_type_i[3*c +: 3] = 3'($urandom_range(0, 7));
        end
        ch_key_valid_i = req;
        if (hold > 0) begin
            core_ready_i = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                check("hold_busy", 128'(busy_o), 128'(0));
            end
            core_ready_i = 1'b1;
        end
        tick();
        check("grant_busy", 128'(busy_o), 128'(1));
        check("grant_owner", 128'(owner_o), 128'(own));
        check("grant_no_ready", 128'(ch_key_ready_o), 128'(0));
        check("grant_no_core_kv", 128'(core_key_valid_o), 128'(0));
        check("grant_done_low", 128'(ch_done_o), 128'(0));
        check("grant_clr_tmo", 128'(ch_timeout_o[own]), 128'(0));
        tick();
        core_bd_i       = $urandom;
        core_bd_valid_i = 1'b1;
        ch_bdo_ready_i  = 4'($urandom_range(0, 15));
        core_done_i       = 1'b1;
        core_auth_valid_i = auth;
        core_tag_match_i  = tag;
        #1;
        e = 128'(core_bd_i) << (32 * own);
        check("sess_key_ready", 128'(ch_key_ready_o), 128'(oh(own)));
        check("sess_core_kv", 128'(core_key_valid_o), 128'(1));
        check("sess_key", 128'(core_key_o), 128'(ch_key_i[32*own +: 32]));
        check("sess_bd_out", 128'(core_bd_o), 128'(ch_bd_i[32*own +: 32]));
        check("sess_type", 128'(core_bd_type_o),
              128'(ch_bd_type_i[3*own +: 3]));
        check("sess_bd_valid", 128'(ch_bd_valid_o), 128'(oh(own)));
        check("sess_ch_bd", ch_bd_o, e);
        check("sess_bdo_ready", 128'(core_bdo_ready_o),
              128'(ch_bdo_ready_i[own]));
        tick();
        core_done_i = 1'b0; core_bd_valid_i = 1'b0;
        core_auth_valid_i = 1'b0; core_tag_match_i = 1'b0;
        check("done_pulse", 128'(ch_done_o), 128'(oh(own)));
        check("done_auth", 128'(ch_auth_valid_o[own]), 128'(auth));
        check("done_tag", 128'(ch_tag_match_o[own]), 128'(tag));
        check("done_idle", 128'(busy_o), 128'(0));
        m_rr = (own + 1) % N;
    endtask

    initial begin
        int idle_n, low_n, own;
        logic [3:0] rq;
        tbl[0] = '{4'b1101, 0, 1'b1, 1'b1};
        tbl[1] = '{4'b1101, 2, 1'b1, 1'b0};
        tbl[2] = '{4'b1101, 3, 1'b0, 1'b0};
        tbl[3] = '{4'b1101, 0, 1'b1, 1'b1};
        tbl[4] = '{4'b0010, 1, 1'b1, 1'b1};
        tbl[5] = '{4'b0011, 0, 1'b0, 1'b1};
        tbl[6] = '{4'b1000, 3, 1'b1, 1'b0};
        tbl[7] = '{4'b0110, 1, 1'b1, 1'b1};
        tbl[8] = '{4'b0110, 2, 1'b0, 1'b0};
        tbl[9] = '{4'b0110, 1, 1'b1, 1'b0};

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_owner", 128'(owner_o), 128'(0));
        check("rst_core_rst", 128'(core_rst_n_o), 128'(1));
        check("rst_done", 128'(ch_done_o), 128'(0));
        check("rst_ready", 128'(ch_key_ready_o), 128'(0));
        check("rst_core_kv", 128'(core_key_valid_o), 128'(0));
        check("rst_tmo", 128'(ch_timeout_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 10; v++)
            run_session(tbl[v].req, tbl[v].own, tbl[v].auth, tbl[v].tag, 0);
        ch_key_valid_i = '0;

        for (int r = 0; r < 20; r++) begin
            rq  = 4'($urandom_range(1, 15));
            own = pick(rq, m_rr);
            run_session(rq, own, 1'($urandom), 1'($urandom),
                        $urandom_range(0, 2));
        end
        ch_key_valid_i = '0;
        tick();

        own = pick(4'b0010, m_rr);
        ch_bd_valid_i = 4'b0010;
        tick();
        check("bp_owner", 128'(owner_o), 128'(own));
        tick();
        ch_bd_valid_i = '0;
        core_bd_valid_i = 1'b1;
        core_bd_i = 32'hCAFE_0001;
        ch_bdo_ready_i = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_core_rdy", 128'(core_bdo_ready_o), 128'(0));
            check("bp_hold", ch_bd_o, 128'(32'hCAFE_0001) << 32);
            check("bp_no_abort", 128'(core_rst_n_o), 128'(1));
            @(posedge clk);
        end
        #1;
        ch_bdo_ready_i = 4'b0010;
        @(negedge clk);
        check("bp_release", 128'(core_bdo_ready_o), 128'(1));
        tick();
        ch_bdo_ready_i = '0; core_bd_valid_i = 1'b0;
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        check("bp_done", 128'(ch_done_o), 128'(4'b0010));
        check("bp_tmo", 128'(ch_timeout_o[1]), 128'(0));
        m_rr = 2;

        ch_key_valid_i = 4'b1100;
        tick();
        check("wd_owner", 128'(owner_o), 128'(2));
        tick();
        check("wd_key_hs", 128'(core_key_valid_o), 128'(1));
        tick();
        ch_key_valid_i = 4'b1000;
        idle_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!core_rst_n_o) break;
            idle_n++;
        end
        check("wd_idle_cycles", 128'(idle_n), 128'(16));
        check("wd_rst_low", 128'(core_rst_n_o), 128'(0));
        check("wd_tmo", 128'(ch_timeout_o[2]), 128'(1));
        check("wd_done", 128'(ch_done_o), 128'(4'b0100));
        check("wd_auth", 128'(ch_auth_valid_o[2]), 128'(0));
        low_n = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (core_rst_n_o) break;
            check("wd_pulse_once", 128'(ch_done_o), 128'(0));
            low_n++;
        end
        check("wd_rst_len", 128'(low_n), 128'(2));
        check("wd_back_idle", 128'(busy_o), 128'(0));
        m_rr = 3;
        run_session(4'b1000, 3, 1'b1, 1'b0, 0);
        check("wd_sticky", 128'(ch_timeout_o[2]), 128'(1));
        ch_key_valid_i = '0;

        ch_key_valid_i = 4'b0100;
        tick();
        check("col_owner", 128'(owner_o), 128'(2));
        check("col_tmo_clr", 128'(ch_timeout_o[2]), 128'(0));
        tick();
        tick();
        ch_key_valid_i = '0;
        repeat (15) tick();
        core_done_i = 1'b1; core_auth_valid_i = 1'b1; core_tag_match_i = 1'b1;
        @(negedge clk);
        check("col_no_early", 128'(core_rst_n_o), 128'(1));
        tick();
        core_done_i = 1'b0; core_auth_valid_i = 1'b0; core_tag_match_i = 1'b0;
        check("col_done", 128'(ch_done_o), 128'(4'b0100));
        check("col_tmo", 128'(ch_timeout_o[2]), 128'(0));
        check("col_tag", 128'(ch_tag_match_o[2]), 128'(1));
        check("col_busy", 128'(busy_o), 128'(0));
        @(negedge clk);
        check("col_no_abort", 128'(core_rst_n_o), 128'(1));
        m_rr = 3;

        ch_bd_valid_i = 4'b0010;
        tick();
        check("ar_owner", 128'(owner_o), 128'(1));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 128'(busy_o), 128'(0));
        check("ar_owner0", 128'(owner_o), 128'(0));
        check("ar_core_bdv", 128'(core_bd_valid_o), 128'(0));
        check("ar_bdi_rdy", 128'(ch_bdi_ready_o), 128'(0));
        check("ar_tag", 128'(ch_tag_match_o), 128'(0));
        check("ar_core_rst", 128'(core_rst_n_o), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        ch_bd_valid_i = 4'b1111;
        tick();
        check("ar_rr_zero", 128'(owner_o), 128'(0));
        check("ar_regrant", 128'(busy_o), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
